// File: rtl/uart_block_rx.sv
// uart_block_rx
//   8N1 UART receiver that gathers NUM_BYTES consecutive bytes (LSB first on
//   the wire, byte 0 in DATA_OUT[7:0]) into one wide word for the multiplier
//   operand path.
//
// Ports
//   CLK_IN       system clock, rising edge
//   resetIn      asynchronous active-high reset
//   UART_RX      serial line, idle high (synchronised internally)
//   DATA_OUT     last delivered word
//   DATA_VALID   DATA_OUT holds an unacknowledged word
//   RECEIVED_IN  consumer acknowledge, level-sampled while DATA_VALID
//   FRAME_ERR    one-cycle pulse on a low stop bit
//   OVERRUN      sticky: a completed word was dropped (cleared by reset only)
module uart_block_rx #(
  parameter int CLKS_PER_BIT = 432,
  parameter int NUM_BYTES    = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                   CLK_IN,
  input  logic                   resetIn,
  input  logic                   UART_RX,
  output logic [8*NUM_BYTES-1:0] DATA_OUT,
  output logic                   DATA_VALID,
  input  logic                   RECEIVED_IN,
  output logic                   FRAME_ERR,
  output logic                   OVERRUN
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TO_CYC   = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_W     = $clog2(TO_CYC);
  localparam int BI_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);
  localparam logic [BI_W-1:0]  BYTE_LAST = BI_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                        state_q, state_d;
  logic                          rx_meta, rx_s;
  logic [CNT_W-1:0]              cnt_q;
  logic [2:0]                    bit_idx_q;
  logic [7:0]                    shift_q;
  logic [BI_W-1:0]               byte_idx_q;
  logic [NUM_BYTES-1:0][7:0]     asm_q;
  logic [TO_W-1:0]               to_cnt_q;
  logic                          word_done_q;

  logic bit_tick, byte_ok, byte_bad, to_fire, last_byte, ack;

  // 2-FF synchroniser; resets to the idle level so a line held low through
  // reset still shows up as a fresh low two cycles after release.
  always_ff @(posedge CLK_IN or posedge resetIn) begin
    if (resetIn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLK_IN or posedge resetIn) begin
    if (resetIn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bit_tick = 1'b0;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    case (state_q)
      // Level-triggered start: no falling-edge detector.
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (cnt_q == CNT_HALF) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          bit_tick = 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      // Leave at mid-stop-bit so a back-to-back start edge is not missed.
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          if (rx_s) begin
            byte_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            byte_bad = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  assign last_byte = (byte_idx_q == BYTE_LAST);
  assign to_fire   = (state_q == S_IDLE) && (byte_idx_q != '0) && (to_cnt_q == TO_LAST);
  assign ack       = DATA_VALID && RECEIVED_IN;

  // Bit timing and byte assembly.
  always_ff @(posedge CLK_IN or posedge resetIn) begin
    if (resetIn) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      to_cnt_q   <= '0;
    end else begin
      // Counter restarts on every state change and on each data-bit sample.
      if (state_d != state_q || bit_tick)
        cnt_q <= '0;
      else if (state_q == S_START || state_q == S_DATA || state_q == S_STOP)
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;

      if (state_q == S_START)
        bit_idx_q <= '0;
      else if (bit_tick)
        bit_idx_q <= (bit_idx_q == 3'd7) ? 3'd0 : bit_idx_q + 3'd1;

      if (bit_tick) shift_q[bit_idx_q] <= rx_s;

      if (byte_ok) asm_q[byte_idx_q] <= shift_q;

      // Bad stop bit or idle timeout abandons the partial word; stale bytes
      // left in asm_q are overwritten before the next word completes.
      if (byte_ok)
        byte_idx_q <= last_byte ? '0 : byte_idx_q + BI_W'(1);
      else if (byte_bad || to_fire)
        byte_idx_q <= '0;

      if (state_q == S_IDLE && byte_idx_q != '0 && !to_fire)
        to_cnt_q <= to_cnt_q + TO_W'(1);
      else
        to_cnt_q <= '0;
    end
  end

  // Delivery handshake. word_done_q lags the final stop sample by one cycle
  // so asm_q already holds the last byte when it is copied out.
  always_ff @(posedge CLK_IN or posedge resetIn) begin
    if (resetIn) begin
      word_done_q <= 1'b0;
      FRAME_ERR   <= 1'b0;
      DATA_OUT    <= '0;
      DATA_VALID  <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      word_done_q <= byte_ok && last_byte;
      FRAME_ERR   <= byte_bad;
      if (word_done_q) begin
        // An ack landing on the completion edge frees the slot for the new word.
        if (!DATA_VALID || ack) begin
          DATA_OUT   <= asm_q;
          DATA_VALID <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (ack) begin
        DATA_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_block_rx.sv
// Bench for uart_block_rx. Bit time is shortened to 32 clocks so the full
// stimulus set stays short; every latency is derived from that bit time.
module tb_uart_block_rx;

  localparam int CPB      = 32;
  localparam int NB       = 16;
  localparam int TOB      = 40;
  localparam int W        = 8 * NB;
  localparam int WORD_LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic         CLK_IN = 1'b0;
  logic         resetIn;
  logic         UART_RX;
  logic         RECEIVED_IN;
  logic [W-1:0] DATA_OUT;
  logic         DATA_VALID;
  logic         FRAME_ERR;
  logic         OVERRUN;

  uart_block_rx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .CLK_IN     (CLK_IN),
    .resetIn    (resetIn),
    .UART_RX    (UART_RX),
    .DATA_OUT   (DATA_OUT),
    .DATA_VALID (DATA_VALID),
    .RECEIVED_IN(RECEIVED_IN),
    .FRAME_ERR  (FRAME_ERR),
    .OVERRUN    (OVERRUN)
  );

  initial forever #5 CLK_IN = ~CLK_IN;

  // Expected events: a finished word or a frame error, keyed by the clock
  // edge (counted from the first edge that sees the start bit) where it lands.
  typedef struct {
    int           cyc;
    bit           is_word;
    logic [W-1:0] data;
  } ev_t;

  ev_t          evq[$];
  logic [7:0]   bq[$];
  int           cyc           = 0;
  int           n_cmp         = 0;
  int           n_fail        = 0;
  int           fe_seen       = 0;
  int           last_done_cyc = 0;
  bit           armed         = 1'b0;
  logic         exp_valid     = 1'b0;
  logic         exp_ovr       = 1'b0;
  logic         exp_fe        = 1'b0;
  logic [W-1:0] exp_data      = '0;
  bit           m_ack, m_done, m_fe;
  logic [W-1:0] m_word;

  // Word-level model: applies scheduled events and the handshake rule.
  initial forever begin
    @(posedge CLK_IN);
    cyc++;
    if (resetIn) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_fe    = 1'b0;
      exp_data  = '0;
      evq.delete();
    end else begin
      m_ack  = exp_valid && RECEIVED_IN;
      m_done = 1'b0;
      m_fe   = 1'b0;
      m_word = '0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        if (evq[0].is_word) begin
          m_done = 1'b1;
          m_word = evq[0].data;
        end else begin
          m_fe = 1'b1;
        end
        void'(evq.pop_front());
      end
      if (m_done) begin
        if (!exp_valid || m_ack) begin
          exp_data  = m_word;
          exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (m_ack) begin
        exp_valid = 1'b0;
      end
      exp_fe = m_fe;
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge CLK_IN);
    if (armed && !resetIn) begin
      n_cmp++;
      if (FRAME_ERR === 1'b1) fe_seen++;
      if (DATA_VALID !== exp_valid || OVERRUN !== exp_ovr ||
          FRAME_ERR !== exp_fe || DATA_OUT !== exp_data) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got v=%b ov=%b fe=%b d=%h, want v=%b ov=%b fe=%b d=%h",
                 cyc, DATA_VALID, OVERRUN, FRAME_ERR, DATA_OUT,
                 exp_valid, exp_ovr, exp_fe, exp_data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // One 8N1 frame; the model is told up front what the frame will produce.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    int           st;
    logic [W-1:0] w;
    ev_t          ev;
    st = cyc + 1;
    if (stop_ok) begin
      bq.push_back(b);
      if (bq.size() == NB) begin
        w = '0;
        for (int k = 0; k < NB; k++) w[8*k +: 8] = bq[k];
        ev.cyc = st + WORD_LAT; ev.is_word = 1'b1; ev.data = w;
        evq.push_back(ev);
        last_done_cyc = st + WORD_LAT;
        bq.delete();
      end
    end else begin
      bq.delete();
      ev.cyc = st + WORD_LAT - 1; ev.is_word = 1'b0; ev.data = '0;
      evq.push_back(ev);
    end
    UART_RX = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (CPB) tick();
    end
    UART_RX = stop_ok;
    repeat (CPB) tick();
    UART_RX = 1'b1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int k = 0; k < NB; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    UART_RX = 1'b1;
    repeat (n * CPB) tick();
    if (n >= TOB) bq.delete();
  endtask

  task automatic apply_reset(input logic line);
    resetIn = 1'b1;
    UART_RX = line;
    bq.delete();
    tick();
    chk("reset DATA_OUT", DATA_OUT, '0);
    chk1("reset DATA_VALID", DATA_VALID, 1'b0);
    chk1("reset OVERRUN", OVERRUN, 1'b0);
    chk1("reset FRAME_ERR", FRAME_ERR, 1'b0);
    repeat (2) tick();
    resetIn = 1'b0;
  endtask

  task automatic ack_pulse();
    RECEIVED_IN = 1'b1;
    tick();
    RECEIVED_IN = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete by cycle %0d", cyc);
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int done0;
    resetIn     = 1'b1;
    UART_RX     = 1'b0;
    RECEIVED_IN = 1'b0;
    tick();

    // Line low through reset, then a full word; pin the completion latency.
    apply_reset(1'b0);
    armed = 1'b1;
    fork
      send_word(128'hFF00FF00FF00FF00FF00FF00FF00FF00);
      begin
        wait (last_done_cyc != 0);
        while (cyc < last_done_cyc - 1) tick();
        chk1("A valid one cycle early", DATA_VALID, 1'b0);
        tick();
        chk1("A valid at latency", DATA_VALID, 1'b1);
      end
    join
    repeat (4) tick();
    chk1("A valid", DATA_VALID, 1'b1);
    chk("A data", DATA_OUT, 128'hFF00FF00FF00FF00FF00FF00FF00FF00);
    chk1("A overrun", OVERRUN, 1'b0);
    chk_int("A frame errors", fe_seen, 0);

    // Ack exactly on the completion edge of the next word.
    done0 = last_done_cyc;
    fork
      send_word(128'hA1B2C3D4E5F60718293A4B5C6D7E8F90);
      begin
        wait (last_done_cyc != done0);
        while (cyc < last_done_cyc - 1) tick();
        ack_pulse();
      end
    join
    repeat (4) tick();
    chk1("C valid", DATA_VALID, 1'b1);
    chk("C data", DATA_OUT, 128'hA1B2C3D4E5F60718293A4B5C6D7E8F90);
    chk1("C overrun", OVERRUN, 1'b0);

    // No ack: second word is dropped and OVERRUN sticks.
    send_word(128'h0123456789ABCDEF0011223344556677);
    repeat (4) tick();
    chk1("B valid", DATA_VALID, 1'b1);
    chk("B data held", DATA_OUT, 128'hA1B2C3D4E5F60718293A4B5C6D7E8F90);
    chk1("B overrun", OVERRUN, 1'b1);
    ack_pulse();
    chk1("B ack clears valid", DATA_VALID, 1'b0);
    chk("B data after ack", DATA_OUT, 128'hA1B2C3D4E5F60718293A4B5C6D7E8F90);
    tick();
    ack_pulse();
    tick();
    chk1("ack while idle ignored", DATA_VALID, 1'b0);

    // Byte 5 with a low stop bit aborts the partial word.
    for (int k = 0; k < 5; k++) send_byte(8'h10 + 8'(k), 1'b1);
    send_byte(8'h3C, 1'b0);
    idle_bits(2);
    send_word(128'h00112233445566778899AABBCCDDEEFF);
    repeat (4) tick();
    chk_int("frame error pulses", fe_seen, 1);
    chk1("D valid", DATA_VALID, 1'b1);
    chk("D data", DATA_OUT, 128'h00112233445566778899AABBCCDDEEFF);
    ack_pulse();

    // Idle timeout discards 7 stale bytes.
    for (int k = 0; k < 7; k++) send_byte(8'hC0 + 8'(k), 1'b1);
    idle_bits(41);
    send_word({16{8'hA5}});
    repeat (4) tick();
    chk1("A5 valid", DATA_VALID, 1'b1);
    chk("A5 data", DATA_OUT, {16{8'hA5}});
    ack_pulse();

    // Reset mid-byte, then a short glitch, then a clean word.
    UART_RX = 1'b0;
    repeat (3 * CPB) tick();
    apply_reset(1'b1);
    idle_bits(1);
    UART_RX = 1'b0;
    repeat (CPB / 4) tick();
    UART_RX = 1'b1;
    repeat (2 * CPB) tick();
    chk1("glitch no valid", DATA_VALID, 1'b0);
    chk_int("glitch no frame error", fe_seen, 1);
    send_word(128'hDEADBEEFCAFEF00D123456789ABCDEF0);
    repeat (4) tick();
    chk1("E valid", DATA_VALID, 1'b1);
    chk("E data", DATA_OUT, 128'hDEADBEEFCAFEF00D123456789ABCDEF0);
    chk1("E overrun", OVERRUN, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
